// File: rtl/fetch_ctrl_if.sv
// Bundles the instruction-memory request/response bus and the decode handshake
// seen by fetch_ctrl. The master modport is the fetch controller's view.
interface fetch_ctrl_if;
    logic        fetch_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;

    modport master (
        input  fetch_en, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, busy
    );

    modport slave (
        output fetch_en, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, busy
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: single outstanding memory request, one-entry
// decode buffer, and redirect handling that flushes the buffer and any in-flight response.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          n_rst,
    fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic        issue;
    logic        load;
    logic        unused_rpc_lsb;

    assign unused_rpc_lsb = ^bus.redirect_pc[1:0];

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a response arriving alongside a redirect still retires the request
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid)         state_d = S_IDLE;
                else if (bus.redirect_valid) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (bus.imem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; issue needs an empty or draining buffer so a load never finds it full
    always_comb begin
        issue = n_rst && (state_q == S_IDLE) && bus.fetch_en && !bus.redirect_valid &&
                (!out_valid_q || bus.out_ready);
        load  = (state_q == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;

    // Datapath next values: redirect beats load, load beats a plain transfer
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;

        if (issue) req_pc_d = fetch_pc_q;

        if (bus.redirect_valid) begin
            fetch_pc_d  = {bus.redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
        end else if (load) begin
            fetch_pc_d  = fetch_pc_q + 32'd4;
            out_valid_d = 1'b1;
            out_instr_d = bus.imem_rdata;
            out_pc_d    = req_pc_q;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= 32'd0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, all checked
// against a transaction-level model (in-flight flag, discard flag, buffer queue).
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if bus0 ();
    fetch_ctrl_if bus1 ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) u_dut0 (.clk(clk), .n_rst(n_rst), .bus(bus0.master));
    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1.master));

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_outst;
    bit          m_discard;
    logic [31:0] buf_pc[$];
    logic [31:0] buf_ins[$];

    // Memory responder state
    bit          pend;
    int          resp_cyc;
    logic [31:0] mem_addr;
    int          fixed_lat;
    int          cyc = 0;
    bit          last_req;
    logic [31:0] last_req_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus0.fetch_en = 0; bus0.out_ready = 0; bus0.redirect_valid = 0; bus0.redirect_pc = 0;
        bus0.imem_rvalid = 0; bus0.imem_rdata = 0;
        bus1.fetch_en = 0; bus1.out_ready = 0; bus1.redirect_valid = 0; bus1.redirect_pc = 0;
        bus1.imem_rvalid = 0; bus1.imem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        idle_inputs();
        #1;
        chk("rst_req",   bus0.imem_req,  0);
        chk("rst_valid", bus0.out_valid, 0);
        chk("rst_pc",    bus0.out_pc,    0);
        chk("rst_instr", bus0.out_instr, 0);
        chk("rst_busy",  bus0.busy,      0);
        chk("rst_addr",  bus0.imem_addr, 32'h0);
        m_pc = 32'h0; m_req_pc = 0; m_outst = 0; m_discard = 0;
        buf_pc.delete(); buf_ins.delete();
        pend = 0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // One clock cycle of dut0: drive, compare against the model, advance the model
    task automatic cycle(input bit en, input bit rdy, input bit redir,
                         input logic [31:0] rpc, input bit stray);
        bit          rv;
        bit          exp_req;
        bit          xfer;
        logic [31:0] rd;
        @(negedge clk);
        rv = (pend && cyc == resp_cyc) || stray;
        rd = pend ? mem_addr + 32'hA000 : 32'hDEAD_BEEF;
        bus0.fetch_en = en; bus0.out_ready = rdy;
        bus0.redirect_valid = redir; bus0.redirect_pc = rpc;
        bus0.imem_rvalid = rv; bus0.imem_rdata = rd;
        #1;
        exp_req = !m_outst && en && !redir && (buf_pc.size() == 0 || rdy);
        chk("req", bus0.imem_req, exp_req);
        if (exp_req) chk("addr", bus0.imem_addr, m_pc);
        chk("valid", bus0.out_valid, buf_pc.size() != 0);
        if (buf_pc.size() != 0) begin
            chk("out_pc", bus0.out_pc, buf_pc[0]);
            chk("out_instr", bus0.out_instr, buf_ins[0]);
        end
        chk("busy", bus0.busy, m_outst);
        last_req = exp_req;
        last_req_addr = m_pc;

        xfer = (buf_pc.size() != 0) && rdy && !redir;
        if (xfer) $display("xfer pc=%08h instr=%08h cyc=%0d", buf_pc[0], buf_ins[0], cyc);

        if (pend && cyc == resp_cyc) pend = 0;
        if (redir) begin
            buf_pc.delete(); buf_ins.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_outst && rv) begin
                m_outst = 0; m_discard = 0;
            end else if (m_outst) begin
                m_discard = 1;
            end
        end else begin
            if (xfer) begin
                void'(buf_pc.pop_front()); void'(buf_ins.pop_front());
            end
            if (rv && m_outst) begin
                if (!m_discard) begin
                    buf_pc.push_back(m_req_pc); buf_ins.push_back(rd);
                    m_pc = m_pc + 32'd4;
                end
                m_outst = 0; m_discard = 0;
            end
            if (exp_req) begin
                m_outst = 1; m_req_pc = m_pc;
                pend = 1; mem_addr = m_pc;
                resp_cyc = cyc + (fixed_lat != 0 ? fixed_lat : int'($urandom_range(1, 4)));
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=%08h exp=%08h", 0, 1);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        idle_inputs();
        do_reset();

        // Reset PC at the top of the address space wraps to 0
        @(negedge clk);
        bus1.fetch_en = 1; bus1.out_ready = 1; #1;
        chk("w_req0",  bus1.imem_req,  1);
        chk("w_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        bus1.imem_rvalid = 1; bus1.imem_rdata = 32'h0000_9FFC; #1;
        chk("w_req1",  bus1.imem_req,  0);
        chk("w_busy1", bus1.busy,      1);
        @(negedge clk);
        bus1.imem_rvalid = 0; #1;
        chk("w_valid", bus1.out_valid, 1);
        chk("w_pc",    bus1.out_pc,    32'hFFFF_FFFC);
        chk("w_instr", bus1.out_instr, 32'h0000_9FFC);
        chk("w_req2",  bus1.imem_req,  1);
        chk("w_addr2", bus1.imem_addr, 32'h0);

        // Back-to-back fetch with 1-cycle memory
        do_reset();
        fixed_lat = 1;
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 0);

        // Decode stalls after the first load, then resumes
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0);

        // Latency 3, redirect two cycles after the request to 8
        do_reset();
        fixed_lat = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1, 1, 0, 0, 0);
            if (last_req && last_req_addr == 32'h8) found = 1;
        end
        chk("find_req8", found, 1);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 32'h0000_0103, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0);

        // Redirect alongside rvalid while PC 4 is buffered, then redirect alongside a real response
        do_reset();
        fixed_lat = 1;
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h40, 1);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 32'h80, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);

        // Reset while waiting on memory, then a stray response after release
        do_reset();
        fixed_lat = 3;
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        do_reset();
        cycle(1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);

        // Randomized traffic with random memory latency
        do_reset();
        fixed_lat = 0;
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 12) == 0, $urandom, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch: owns the fetch PC, issues single-outstanding requests to the instruction memory and buffers one returned instruction for decode behind a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffered instruction and discarding any in-flight memory response.
- Sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous active-low reset.
- fetch_en  in  1  allows new requests to be issued; an outstanding request still completes when low.
- imem_req  out  1  request strobe, one cycle per request; combinational.
- imem_addr  out  32  request address; equals fetch_pc; valid when imem_req=1.
- imem_rvalid  in  1  response valid; arrives at least 1 cycle after imem_req.
- imem_rdata  in  32  response instruction word.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0 internally.
- out_valid  out  1  buffered instruction available to decode.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  32  buffered instruction.
- out_pc  out  32  PC of out_instr.
- busy  out  1  high when state is WAIT or FLUSH.

Behaviour:
- Reset (async, n_rst=0):
  - fetch_pc=RESET_PC, state=IDLE.
  - out_valid=0, out_instr=0, out_pc=0, req_pc=0.
  - imem_req=0 while in reset.
- State IDLE (nothing outstanding):
  - imem_req = fetch_en & !redirect_valid & (!out_valid | out_ready).
  - When imem_req=1: req_pc<=fetch_pc, go to WAIT.
  - imem_rvalid in IDLE is ignored.
- State WAIT, on imem_rvalid & !redirect_valid:
  - out_valid<=1, out_instr<=imem_rdata, out_pc<=req_pc.
  - fetch_pc<=fetch_pc+4, modulo 2^32 (32'hFFFF_FFFC+4=0).
  - Go to IDLE.
  - The buffer is always free at this point because issue requires an empty or draining buffer. No request is issued in WAIT.
- State FLUSH: on imem_rvalid, discard the data and go to IDLE. No buffer or fetch_pc update from the response.
- Redirect (redirect_valid=1), in any state:
  - fetch_pc<={redirect_pc[31:2],2'b00}; out_valid<=0, which drops any unaccepted instruction.
  - IDLE: no request that cycle, stay IDLE.
  - WAIT without rvalid: go to FLUSH.
  - WAIT with rvalid in the same cycle: discard the response, go to IDLE.
  - FLUSH: stay FLUSH, keep the latest target.
  - Redirect has priority over out_ready and over a response in the same cycle.
- Output handshake:
  - A transfer occurs when out_valid & out_ready.
  - out_valid, out_instr and out_pc stay stable until accepted or flushed.
  - On a transfer with no new load, out_valid<=0. If a load and a transfer occur in the same cycle, the load wins (out_valid stays 1).
- Throughput: 1 instruction per 2 cycles with 1-cycle memory latency; 1 per (L+1) cycles with latency L.
- fetch_en falling while in WAIT: the response still completes into the buffer; no further issue.
- Reset mid-WAIT: everything returns to reset values. A late imem_rvalid that arrives in IDLE is ignored.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, memory latency 1, mem[i]=i*4+32'hA000:
  - imem_addr sequence 0,4,8 on cycles 0,2,4.
  - out_pc/out_instr = 0/A000, 4/A004, 8/A008.
- out_ready=0 after the first load:
  - Exactly one request is issued, out_valid stays 1 with out_instr=A000 held stable, imem_req stays 0.
  - Raising out_ready gives a transfer and a request in the same cycle with imem_addr=4.
- Latency 3, redirect_valid with redirect_pc=32'h0000_0103 two cycles after a request to 8:
  - Enter FLUSH; the response to 8 is discarded and out_valid stays 0.
  - Next imem_addr=32'h100, out_pc=32'h100.
- Redirect to 32'h40 in the same cycle as imem_rvalid, with a valid buffered instruction at PC 4:
  - Buffer cleared, response discarded, state IDLE.
  - Next imem_addr=32'h40.
- RESET_PC=32'hFFFF_FFFC: out_pc=FFFF_FFFC, then next imem_addr=0 (wrap).
- n_rst asserted during WAIT, then imem_rvalid pulsed after release:
  - Outputs are at reset values during reset.
  - The stray rvalid is ignored; the first imem_addr=RESET_PC.
